// File: rtl/chipbus_responder.sv
// Chip-bus responder: per bus slot, runs the Agnus DMA cycle or grants the slot to a
// pending CPU chip-RAM access, and raises bls when the CPU has been starved too long.
module chipbus_responder #(
  parameter int         BLS_THRESH = 3,
  parameter logic [2:0] CHIP_TOP   = 3'b000
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk7_en,
  input  logic        dbr,
  input  logic        dbwe,
  input  logic [20:1] dma_address,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [23:1] cpu_address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bls,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, DMA, CPU} state_t;

  localparam logic [1:0] THRESH = BLS_THRESH[1:0];

  state_t     state;
  logic [1:0] denials;
  logic [1:0] denials_next;
  logic       chip_req;
  logic       done;
  logic       free;
  logic       grant_dma;
  logic       grant_cpu;

  assign chip_req  = cpu_req && (cpu_address[23:21] == CHIP_TOP);
  assign done      = (state != IDLE) && mem_ack;
  // A completion on the same clk as a slot frees that slot for a fresh decision.
  assign free      = (state == IDLE) || done;
  assign grant_dma = clk7_en && free && dbr;
  assign grant_cpu = clk7_en && free && !dbr && chip_req;

  always_comb begin
    denials_next = denials;
    if (clk7_en) begin
      if (dbr && chip_req) begin
        if (denials != THRESH) denials_next = denials + 2'd1;
      end else if (grant_cpu || !cpu_req) begin
        denials_next = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state     <= IDLE;
      denials   <= 2'd0;
      dma_rdata <= 16'd0;
      cpu_rdata <= 16'd0;
      cpu_ack   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_addr  <= 20'd0;
      mem_wdata <= 16'd0;
      bls       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      denials <= denials_next;
      bls     <= (denials_next == THRESH);

      if (done) begin
        mem_req <= 1'b0;
        state   <= IDLE;
        if (!mem_we) begin
          if (state == DMA) dma_rdata <= mem_rdata;
          else              cpu_rdata <= mem_rdata;
        end
        // A CPU that gave up mid-access gets no acknowledge.
        if (state == CPU) cpu_ack <= cpu_req;
      end

      if (clk7_en && !free) overrun <= 1'b1;

      if (grant_dma) begin
        state     <= DMA;
        mem_req   <= 1'b1;
        mem_we    <= dbwe;
        mem_be    <= 2'b11;
        mem_addr  <= dma_address;
        mem_wdata <= dma_wdata;
      end else if (grant_cpu) begin
        state     <= CPU;
        mem_req   <= 1'b1;
        mem_we    <= cpu_we;
        mem_be    <= {cpu_uds, cpu_lds};
        mem_addr  <= cpu_address[20:1];
        mem_wdata <= cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_chipbus_responder.sv
// Bench for chipbus_responder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_chipbus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk7_en, dbr, dbwe;
  logic [20:1] dma_address;
  logic [15:0] dma_wdata, dma_rdata;
  logic        cpu_req, cpu_we, cpu_uds, cpu_lds;
  logic [23:1] cpu_address;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack, bls, overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chipbus_responder #(.BLS_THRESH(3), .CHIP_TOP(3'b000)) dut (
    .clk(clk), ._reset(rst_n), .clk7_en(clk7_en), .dbr(dbr), .dbwe(dbwe),
    .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bls(bls), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transfer (or none), with what the port must show for it.
  bit          m_busy, m_is_cpu, m_req, m_we, m_ack, m_ovr, m_bls;
  logic [1:0]  m_be;
  logic [19:0] m_addr;
  logic [15:0] m_wdata, m_drd, m_crd;
  int          m_starved;

  task automatic model_clear();
    m_busy = 0; m_is_cpu = 0; m_req = 0; m_we = 0; m_ack = 0; m_ovr = 0; m_bls = 0;
    m_be = 0; m_addr = 0; m_wdata = 0; m_drd = 0; m_crd = 0; m_starved = 0;
  endtask

  task automatic model_step();
    bit chip, cpu_won;
    if (!rst_n) begin
      model_clear();
      return;
    end
    m_ack = 0;
    if (m_busy && mem_ack) begin
      m_busy = 0;
      m_req  = 0;
      if (!m_we) begin
        if (m_is_cpu) m_crd = mem_rdata; else m_drd = mem_rdata;
      end
      if (m_is_cpu && cpu_req) m_ack = 1;
    end
    if (clk7_en) begin
      chip    = cpu_req && (cpu_address[23:21] == 3'b000);
      cpu_won = 0;
      if (m_busy) m_ovr = 1;
      else if (dbr) begin
        m_busy = 1; m_is_cpu = 0; m_req = 1; m_we = dbwe; m_be = 2'b11;
        m_addr = dma_address; m_wdata = dma_wdata;
      end else if (chip) begin
        m_busy = 1; m_is_cpu = 1; m_req = 1; m_we = cpu_we; m_be = {cpu_uds, cpu_lds};
        m_addr = cpu_address[20:1]; m_wdata = cpu_wdata; cpu_won = 1;
      end
      if (dbr && chip)              m_starved = (m_starved >= 3) ? 3 : m_starved + 1;
      else if (cpu_won || !cpu_req) m_starved = 0;
      m_bls = (m_starved == 3);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("m.mem_req", mem_req, m_req);
    chk("m.mem_we", mem_we, m_we);
    chk("m.mem_be", mem_be, m_be);
    chk("m.mem_addr", mem_addr, m_addr);
    chk("m.mem_wdata", mem_wdata, m_wdata);
    chk("m.dma_rdata", dma_rdata, m_drd);
    chk("m.cpu_rdata", cpu_rdata, m_crd);
    chk("m.cpu_ack", cpu_ack, m_ack);
    chk("m.bls", bls, m_bls);
    chk("m.overrun", overrun, m_ovr);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic dma_slot(input logic we, input logic [19:0] a, input logic [15:0] rd);
    dbr = 1; dbwe = we; dma_address = a; clk7_en = 1;
    step();
    dbr = 0; clk7_en = 0;
    step();
    mem_ack = 1; mem_rdata = rd;
    step();
    mem_ack = 0;
  endtask

  initial begin
    model_clear();
    rst_n = 0; clk7_en = 0; dbr = 0; dbwe = 0; dma_address = 0; dma_wdata = 0;
    cpu_req = 0; cpu_we = 0; cpu_uds = 0; cpu_lds = 0; cpu_address = 0; cpu_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    step(); step();
    rst_n = 1;
    chk("rst.mem_req", mem_req, 0);
    chk("rst.bls", bls, 0);
    chk("rst.overrun", overrun, 0);

    // DMA read, ack three clocks later
    dbr = 1; dbwe = 0; dma_address = 20'h01234; dma_wdata = 16'h7777; clk7_en = 1;
    step();
    dbr = 0; clk7_en = 0;
    chk("dma.mem_req", mem_req, 1);
    chk("dma.mem_addr", mem_addr, 20'h01234);
    chk("dma.mem_be", mem_be, 2'b11);
    step(); step();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 0; mem_rdata = 16'h0000;
    chk("dma.rdata", dma_rdata, 16'hBEEF);
    chk("dma.mem_req_drop", mem_req, 0);
    step();
    chk("dma.rdata_held", dma_rdata, 16'hBEEF);
    chk("dma.cpu_ack", cpu_ack, 0);

    // CPU starved by three DMA slots, then granted
    cpu_req = 1; cpu_we = 0; cpu_uds = 1; cpu_lds = 1; cpu_address = 23'h000100;
    dma_slot(0, 20'h00010, 16'h1111);
    chk("bls.after1", bls, 0);
    dma_slot(0, 20'h00020, 16'h2222);
    dma_slot(0, 20'h00030, 16'h3333);
    chk("bls.after3", bls, 1);
    chk("bls.no_ack", cpu_ack, 0);
    clk7_en = 1;
    step();
    clk7_en = 0;
    chk("bls.cpu_grant", mem_req, 1);
    chk("bls.cpu_addr", mem_addr, 20'h00100);
    chk("bls.cleared", bls, 0);
    mem_ack = 1; mem_rdata = 16'h1234;
    step();
    mem_ack = 0;
    chk("cpu.ack", cpu_ack, 1);
    chk("cpu.rdata", cpu_rdata, 16'h1234);
    cpu_req = 0;
    step();
    chk("cpu.ack_once", cpu_ack, 0);

    // CPU lower-byte write
    cpu_req = 1; cpu_we = 1; cpu_uds = 0; cpu_lds = 1; cpu_wdata = 16'h00AA;
    cpu_address = 23'h000200; clk7_en = 1;
    step();
    clk7_en = 0;
    chk("bw.mem_be", mem_be, 2'b01);
    chk("bw.mem_we", mem_we, 1);
    chk("bw.mem_wdata", mem_wdata, 16'h00AA);
    chk("bw.mem_addr", mem_addr, 20'h00200);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("bw.ack", cpu_ack, 1);
    cpu_req = 0;
    step();
    chk("bw.ack_once", cpu_ack, 0);

    // Non-chip CPU address is never serviced
    cpu_req = 1; cpu_we = 0; cpu_address = 23'h200000;
    for (int i = 0; i < 3; i++) begin
      clk7_en = 1;
      step();
      clk7_en = 0;
      chk("nc.mem_req", mem_req, 0);
      step();
      chk("nc.cpu_ack", cpu_ack, 0);
    end
    cpu_req = 0;

    // Completion coincident with the next slot: back-to-back DMA, no overrun
    dbr = 1; dbwe = 0; dma_address = 20'h00111; clk7_en = 1;
    step();
    dbr = 0; clk7_en = 0;
    step();
    mem_ack = 1; mem_rdata = 16'h5555; clk7_en = 1; dbr = 1; dma_address = 20'h00222;
    step();
    mem_ack = 0; clk7_en = 0; dbr = 0;
    chk("b2b.mem_req", mem_req, 1);
    chk("b2b.mem_addr", mem_addr, 20'h00222);
    chk("b2b.overrun", overrun, 0);
    chk("b2b.rdata", dma_rdata, 16'h5555);
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();

    // Overrun: slot arrives with the access still outstanding
    dbr = 1; dbwe = 1; dma_address = 20'h00ABC; dma_wdata = 16'h1111; clk7_en = 1;
    step();
    dbr = 0; clk7_en = 0;
    step();
    dbr = 1; dma_address = 20'h00DEF; clk7_en = 1;
    step();
    dbr = 0; clk7_en = 0;
    chk("ovr.flag", overrun, 1);
    chk("ovr.addr_held", mem_addr, 20'h00ABC);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("ovr.no_second", mem_req, 0);
    step();
    chk("ovr.sticky", overrun, 1);

    // Reset in the middle of a CPU access; the late ack is ignored
    cpu_req = 1; cpu_we = 0; cpu_uds = 1; cpu_lds = 1; cpu_address = 23'h000300; clk7_en = 1;
    step();
    clk7_en = 0;
    chk("rmid.mem_req", mem_req, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rmid.mem_req0", mem_req, 0);
    chk("rmid.overrun0", overrun, 0);
    chk("rmid.dma_rdata0", dma_rdata, 0);
    chk("rmid.mem_addr0", mem_addr, 0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("rmid.no_ack", cpu_ack, 0);
    cpu_req = 0;
    step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n       = !($urandom_range(0, 599) == 0);
      clk7_en     = ($urandom_range(0, 3) == 0);
      dbr         = ($urandom_range(0, 2) == 0);
      dbwe        = $urandom_range(0, 1);
      dma_address = 20'($urandom);
      dma_wdata   = 16'($urandom);
      mem_rdata   = 16'($urandom);
      if (mem_req && !mem_ack) mem_ack = ($urandom_range(0, 2) == 0);
      else                     mem_ack = !mem_req && ($urandom_range(0, 63) == 0);
      if (cpu_req && cpu_ack) cpu_req = 0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req     = 1;
        cpu_we      = $urandom_range(0, 1);
        cpu_uds     = $urandom_range(0, 1);
        cpu_lds     = $urandom_range(0, 1);
        cpu_wdata   = 16'($urandom);
        cpu_address = {($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                       20'($urandom)};
      end else if (cpu_req && $urandom_range(0, 29) == 0) cpu_req = 0;
      step();
    end

    rst_n = 1; clk7_en = 0; dbr = 0; cpu_req = 0; mem_ack = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
